// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I-cache / D-cache memory-port arbiter.
// The line-base helper works on a wide word address so any ADDR_W up to 64 fits.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } arb_owner_t;

   localparam int MAX_ADDR_W = 64;

   // Clears the beat-select bits so the burst always starts at the line base.
   function automatic logic [MAX_ADDR_W-1:0] line_base(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int unsigned          line_words);
      return addr & ~(MAX_ADDR_W'(line_words) - MAX_ADDR_W'(1));
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Grants the single backing-memory word port to the I-cache or D-cache and
// sequences a LINE_WORDS-beat refill or writeback burst for the owner.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_gnt,
   output logic              ic_rvalid,
   output logic [DATA_W-1:0] ic_rdata,
   output logic              ic_done,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_gnt,
   output logic              dc_rvalid,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_done,
   output logic              dc_wready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output arb_state_t        dbg_state_o
);

   localparam int                BEAT_W    = $clog2(LINE_WORDS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   arb_state_t        state_q;
   arb_owner_t        owner_q;
   arb_owner_t        last_owner_q;
   logic [BEAT_W-1:0] beat_q;
   logic [ADDR_W-1:0] line_q;
   logic              we_q;

   arb_owner_t        owner_d;
   logic [ADDR_W-1:0] line_d;

   // Both pending: the requester served least recently wins.
   function automatic arb_owner_t pick_owner(input logic ic, input logic dc, input arb_owner_t last);
      if (ic && dc) begin
         return (last == OWN_IC) ? OWN_DC : OWN_IC;
      end else if (dc) begin
         return OWN_DC;
      end else begin
         return OWN_IC;
      end
   endfunction

   assign owner_d = pick_owner(ic_req, dc_req, last_owner_q);
   assign line_d  = ADDR_W'(line_base(MAX_ADDR_W'((owner_d == OWN_DC) ? dc_addr : ic_addr),
                                      LINE_WORDS));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IC;
         last_owner_q <= OWN_IC;
         beat_q       <= '0;
         line_q       <= '0;
         we_q         <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ic_req || dc_req) begin
                  owner_q <= owner_d;
                  line_q  <= line_d;
                  we_q    <= (owner_d == OWN_DC) && dc_we;
                  beat_q  <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (mem_valid) begin
                  beat_q <= beat_q + BEAT_W'(1);
                  if (beat_q == LAST_BEAT) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               last_owner_q <= owner_q;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory handshake: mem_req holds the beat's address/we until a one-cycle
   // mem_valid completes it; read data passes straight through to the owner.
   logic busy, done_st, own_dc, beat_ok;

   assign busy    = (state_q == BUSY);
   assign done_st = (state_q == DONE);
   assign own_dc  = (owner_q == OWN_DC);
   assign beat_ok = busy && mem_valid;

   assign ic_gnt    = (busy || done_st) && !own_dc;
   assign dc_gnt    = (busy || done_st) && own_dc;
   assign ic_rvalid = beat_ok && !we_q && !own_dc;
   assign dc_rvalid = beat_ok && !we_q && own_dc;
   assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
   assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
   assign ic_done   = done_st && !own_dc;
   assign dc_done   = done_st && own_dc;
   assign dc_wready = beat_ok && we_q;

   assign mem_req   = busy;
   assign mem_we    = busy && we_q;
   assign mem_addr  = busy ? (line_q | ADDR_W'(beat_q)) : '0;
   assign mem_wdata = (busy && we_q) ? dc_wdata : '0;

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven bursts, a beat scoreboard
// fed by a latency-configurable memory model, and hand-written corner sequences.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic        clock, reset;
   logic        ic_req, dc_req, dc_we;
   logic [31:0] ic_addr, dc_addr, dc_wdata;
   logic        ic_gnt, ic_rvalid, ic_done;
   logic [31:0] ic_rdata;
   logic        dc_gnt, dc_rvalid, dc_done, dc_wready;
   logic [31:0] dc_rdata;
   logic        mem_req, mem_we, mem_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   arb_state_t  dbg_state;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
      .clock(clock), .reset(reset),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
      .ic_rdata(ic_rdata), .ic_done(ic_done),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
      .dc_wready(dc_wready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_valid(mem_valid), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout required finish");
      $fatal(1);
   end

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   logic [65:0] exp_q[$];      // {is_dc, we, addr, data}
   logic [65:0] mon_e;
   int  ic_done_cnt = 0, dc_done_cnt = 0;
   bit  mon_en = 0;

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic push_burst(input logic is_dc, input logic we, input logic [31:0] base);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({is_dc, we, base + 32'(k), we ? (32'hA0 + 32'(k)) : mem_word(base + 32'(k))});
      end
   endtask

   // ---------------- memory model ----------------
   int mem_lat = 1;
   int mem_cnt = 0;
   bit valid_always = 0;

   always @(negedge clock) begin
      mem_valid = 1'b0;
      mem_rdata = '0;
      if (reset) begin
         mem_cnt = 0;
      end else if (mem_req) begin
         mem_cnt++;
         if (valid_always || mem_cnt >= mem_lat) begin
            mem_cnt   = 0;
            mem_valid = 1'b1;
            if (!mem_we) mem_rdata = mem_word(mem_addr);
         end
      end else begin
         mem_cnt = 0;
         if (valid_always) begin
            mem_valid = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
         end
      end
   end

   // ---------------- writeback data driver ----------------
   bit wb_adv = 0;
   int wb_idx = 0;

   always @(posedge clock) begin
      #1;
      if (wb_adv) begin
         wb_adv   = 0;
         wb_idx++;
         dc_wdata = 32'hA0 + 32'(wb_idx);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      #1;
      if (mon_en && !reset) begin
         if (ic_done) ic_done_cnt++;
         if (dc_done) dc_done_cnt++;
         check("gnt_exclusive", ic_gnt & dc_gnt, 0);
         check("rdata_zero_when_idle", {ic_rvalid ? 32'h0 : ic_rdata, dc_rvalid ? 32'h0 : dc_rdata}, 0);
         if (mem_valid && mem_req) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("beat_owner", {ic_gnt, dc_gnt}, {~mon_e[65], mon_e[65]});
               check("beat_addr", mem_addr, mon_e[63:32]);
               check("beat_we", mem_we, mon_e[64]);
               if (mon_e[64]) begin
                  check("wb_data", mem_wdata, mon_e[31:0]);
                  check("wb_ready", {dc_wready, ic_rvalid, dc_rvalid}, 3'b100);
               end else begin
                  check("rd_valid", {ic_rvalid, dc_rvalid, dc_wready}, {~mon_e[65], mon_e[65], 1'b0});
                  check("rd_data", mon_e[65] ? dc_rdata : ic_rdata, mon_e[31:0]);
                  check("rd_wdata_zero", mem_wdata, 0);
               end
            end
         end else begin
            check("no_beat_pulse", {ic_rvalid, dc_rvalid, dc_wready}, 0);
         end
         if (dc_wready) wb_adv = 1;
      end
   end

   // ---------------- driver tasks ----------------
   typedef struct {
      logic        ic_req;
      logic        dc_req;
      logic        dc_we;
      logic [31:0] ic_addr;
      logic [31:0] dc_addr;
      int          lat;
      logic        exp_dc;
      logic [31:0] exp_base;
   } vec_t;

   task automatic wait_gnt(output int n, output bit ok);
      ok = 0;
      n  = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clock); #1;
         n++;
         if (ic_gnt || dc_gnt) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_done(output int n, output bit ok);
      ok = 0;
      n  = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clock); #1;
         n++;
         if (ic_done || dc_done) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, dc_wready, mem_req, mem_we}, 0);
      check({tag, "_data"}, ic_rdata | dc_rdata | mem_addr | mem_wdata, 0);
      check({tag, "_state"}, dbg_state, IDLE);
   endtask

   task automatic run_row(input vec_t v, input string tag);
      int n;
      bit ok;
      mem_lat = v.lat;
      ic_addr = v.ic_addr;
      dc_addr = v.dc_addr;
      dc_we   = v.dc_we;
      if (v.exp_dc && v.dc_we) begin
         wb_idx   = 0;
         dc_wdata = 32'hA0;
      end else begin
         dc_wdata = 32'h0;
      end
      push_burst(v.exp_dc, v.exp_dc & v.dc_we, v.exp_base);
      ic_req = v.ic_req;
      dc_req = v.dc_req;
      wait_gnt(n, ok);
      check({tag, "_gnt_seen"}, ok, 1);
      check({tag, "_gnt_lat"}, n, 1);
      check({tag, "_gnt_owner"}, {ic_gnt, dc_gnt}, {~v.exp_dc, v.exp_dc});
      check({tag, "_addr0"}, mem_addr, v.exp_base);
      check({tag, "_mem_req"}, mem_req, 1);
      check({tag, "_we"}, mem_we, v.exp_dc & v.dc_we);
      wait_done(n, ok);
      check({tag, "_done_seen"}, ok, 1);
      check({tag, "_burst_len"}, n, 4 * v.lat);
      check({tag, "_done_owner"}, {ic_done, dc_done, mem_req}, {~v.exp_dc, v.exp_dc, 1'b0});
      ic_req = 0;
      dc_req = 0;
      @(posedge clock); #1;
      check({tag, "_back_idle"}, {ic_gnt, dc_gnt, ic_done, dc_done, mem_req}, 0);
   endtask

   // ---------------- test sequence ----------------
   vec_t vecs[6];

   initial begin
      int   n;
      bit   ok;
      bit   early;
      logic tdc;
      int   ic_snap, dc_snap;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40,       32'h0,   2, 1'b0, 32'h40};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h207, 1, 1'b1, 32'h204};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h103, 3, 1'b1, 32'h100};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h9F,       32'h55,  1, 1'b0, 32'h9C};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h10,       32'h23,  2, 1'b1, 32'h20};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,   1, 1'b0, 32'hFFFFFFFC};

      reset = 1; ic_req = 0; dc_req = 0; dc_we = 0;
      ic_addr = 0; dc_addr = 0; dc_wdata = 0;
      #3;
      check_zero("rst_hold");
      @(posedge clock); @(posedge clock); #1;
      reset = 0;
      #1;
      check_zero("rst_rel");
      mon_en = 1;

      // Tie after reset: DC first, then strict alternation while both held.
      mem_lat = 1; ic_addr = 32'h300; dc_addr = 32'h401; dc_we = 0;
      push_burst(1, 0, 32'h400); push_burst(0, 0, 32'h300);
      push_burst(1, 0, 32'h400); push_burst(0, 0, 32'h300);
      ic_req = 1; dc_req = 1;
      for (int b = 0; b < 4; b++) begin
         tdc = (b % 2 == 0);
         wait_gnt(n, ok);
         check("tie_gnt_seen", ok, 1);
         check("tie_gnt_lat", n, (b == 0) ? 1 : 2);
         check("tie_owner", {ic_gnt, dc_gnt}, {~tdc, tdc});
         wait_done(n, ok);
         check("tie_done_seen", ok, 1);
         check("tie_done_owner", {ic_done, dc_done}, {~tdc, tdc});
         if (b == 3) begin
            ic_req = 0;
            dc_req = 0;
         end
      end
      @(posedge clock); #1;
      check("tie_back_idle", {ic_gnt, dc_gnt, mem_req}, 0);

      for (int i = 0; i < 6; i++) run_row(vecs[i], $sformatf("vec%0d", i));

      // Late request: DC arrives mid IC burst and waits for IDLE.
      mem_lat = 2; ic_addr = 32'h500; dc_addr = 32'h600; dc_we = 0;
      push_burst(0, 0, 32'h500);
      ic_req = 1;
      wait_gnt(n, ok);
      check("late_ic_gnt_seen", ok, 1);
      repeat (2) begin @(posedge clock); #1; end
      push_burst(1, 0, 32'h600);
      dc_req = 1;
      early = 0; ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clock); #1;
         if (dc_gnt) early = 1;
         if (ic_done) begin
            ok = 1;
            break;
         end
      end
      check("late_ic_done_seen", ok, 1);
      check("late_dc_held_off", early, 0);
      ic_req = 0;
      ok = 0; n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clock); #1;
         n++;
         if (dc_gnt) begin
            ok = 1;
            break;
         end
      end
      check("late_dc_gnt_seen", ok, 1);
      check("late_gap", n, 2);
      check("late_mem_req", mem_req, 1);
      wait_done(n, ok);
      check("late_dc_done", {ok, dc_done}, 2'b11);
      dc_req = 0;
      @(posedge clock); #1;

      // Spurious mem_valid in IDLE and DONE.
      valid_always = 1;
      repeat (3) begin @(posedge clock); #1; end
      run_row('{1'b1, 1'b0, 1'b0, 32'h800, 32'h0,   1, 1'b0, 32'h800}, "spur_ic");
      run_row('{1'b0, 1'b1, 1'b1, 32'h0,   32'h903, 1, 1'b1, 32'h900}, "spur_dc");
      valid_always = 0;

      // Reset mid-burst, then a fresh request restarts at beat 0.
      mem_lat = 2; ic_addr = 32'h702;
      push_burst(0, 0, 32'h700);
      ic_req = 1;
      wait_gnt(n, ok);
      check("rst_mid_gnt_seen", ok, 1);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clock); #1;
         if (exp_q.size() == 3) begin
            ok = 1;
            break;
         end
      end
      check("rst_mid_beat1_seen", ok, 1);
      ic_snap = ic_done_cnt;
      dc_snap = dc_done_cnt;
      #2;
      ic_req = 0;
      reset  = 1;
      #1;
      check_zero("rst_mid");
      exp_q.delete();
      repeat (2) @(posedge clock);
      #1;
      reset = 0;
      #1;
      check_zero("rst_mid_rel");
      repeat (2) begin @(posedge clock); #1; end
      check("rst_mid_no_done", {ic_done_cnt, dc_done_cnt}, {ic_snap, dc_snap});
      run_row('{1'b1, 1'b0, 1'b0, 32'h702, 32'h0, 2, 1'b0, 32'h700}, "rst_restart");

      check("sb_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
